// File: rtl/sincos_pkg.sv
// Shared constants, state encoding and arctangent table for sincos_to_angle.
// Angle constants are Q12 radians; ATAN entries are Q(12+GUARD) radians.
package sincos_pkg;

  localparam int unsigned N        = 24;             // sign-magnitude word width
  localparam int unsigned Q        = 12;             // fractional bits
  localparam int unsigned GUARD    = 2;              // extra internal LSBs
  localparam int unsigned ITER_DEF = 14;             // default CORDIC iterations
  localparam int unsigned W        = N + 2 + GUARD;  // internal two's complement width

  // 1/K = 0.607253 (2487 at Q12); kept at 16 fractional bits so the gain
  // correction adds well under one output LSB of error at full scale.
  localparam int unsigned KF    = 16;
  localparam int unsigned K_INV = 39797;

  localparam int PI      = 12868;  // 0x003244
  localparam int HALF_PI = 6434;
  localparam int TWO_PI  = 25736;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROT   = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // atan(2^-i) * 2^(Q+GUARD), rounded to nearest
  function automatic logic signed [W-1:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = W'(12868);
      4'd1:    atan_lut = W'(7596);
      4'd2:    atan_lut = W'(4014);
      4'd3:    atan_lut = W'(2037);
      4'd4:    atan_lut = W'(1023);
      4'd5:    atan_lut = W'(512);
      4'd6:    atan_lut = W'(256);
      4'd7:    atan_lut = W'(128);
      4'd8:    atan_lut = W'(64);
      4'd9:    atan_lut = W'(32);
      4'd10:   atan_lut = W'(16);
      4'd11:   atan_lut = W'(8);
      4'd12:   atan_lut = W'(4);
      4'd13:   atan_lut = W'(2);
      4'd14:   atan_lut = W'(1);
      default: atan_lut = W'(0);
    endcase
  endfunction

endpackage

// File: rtl/sincos_to_angle_qsm_to_tc.sv
// Q12.12 sign-magnitude to W-bit two's complement with GUARD extra LSBs.
// Negative zero maps to 0 because negating a zero magnitude yields zero.
//   i_sm    : sign-magnitude input, bit N-1 = sign
//   o_tc_c  : combinational two's complement result, Q(12+GUARD)
module qsm_to_tc
  import sincos_pkg::*;
(
  input  logic [N-1:0]        i_sm,
  output logic signed [W-1:0] o_tc_c
);

  logic signed [W-1:0] mag_c;

  always_comb begin
    mag_c  = W'({i_sm[N-2:0], {GUARD{1'b0}}});
    o_tc_c = i_sm[N-1] ? -mag_c : mag_c;
  end

endmodule

// File: rtl/sincos_to_angle.sv
// Recovers rotor angle and vector magnitude from a SinQ/CosQ pair using an
// iterative vectoring CORDIC, one micro-rotation per clock.
// Optional macro SINCOS_UNSIGNED_ANGLE_EN: angle reported in [0, 2pi).
//   clk, reset      : clock, asynchronous active-low reset
//   i_start         : request, sampled only while idle
//   i_sin, i_cos    : Q12.12 sign-magnitude inputs
//   o_angle         : radians, Q12.12 sign-magnitude, (-pi, pi]
//   o_mag           : gain-compensated magnitude, sign bit always 0
//   o_valid         : one-cycle pulse when results update
//   o_busy          : high from the cycle after acceptance until o_valid
//   o_zero          : input vector was (0,0)
//   o_overflow      : magnitude saturated
// ITER legal range is 8..16.
module sincos_to_angle
  import sincos_pkg::*;
#(
  parameter int unsigned ITER = ITER_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_start,
  input  logic [N-1:0] i_sin,
  input  logic [N-1:0] i_cos,
  output logic [N-1:0] o_angle,
  output logic [N-1:0] o_mag,
  output logic         o_valid,
  output logic         o_busy,
  output logic         o_zero,
  output logic         o_overflow
);

  localparam int unsigned NM1 = N - 1;
  localparam int unsigned PW  = W + KF;
  localparam int unsigned SH  = GUARD + KF;
  localparam logic [PW-1:0]       RND      = PW'(64'd1 << (SH - 1));
  localparam logic [PW-1:0]       MAG_MAX  = PW'((64'd1 << (N - 1)) - 64'd1);
  localparam logic signed [W-1:0] PI_W     = W'(PI);
  localparam logic signed [W-1:0] TWO_PI_W = W'(TWO_PI);
  localparam logic signed [W-1:0] PI_G     = W'(PI << GUARD);

  state_e              state_q, state_d;
  logic [3:0]          it_q, it_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                x_neg_q, x_neg_d, y_neg_q, y_neg_d;
  logic                x_zero_q, x_zero_d, y_zero_q, y_zero_d, zero_q, zero_d;
  logic [N-2:0]        axis_q, axis_d;
  logic signed [N-1:0] ang_q, ang_d;
  logic [N-2:0]        mag_q, mag_d;
  logic                ovf_q, ovf_d;
  logic [N-1:0]        angle_q, angle_d, omag_q, omag_d;
  logic                valid_q, valid_d, busy_q, busy_d;
  logic                ozero_q, ozero_d, oovf_q, oovf_d;

  logic signed [W-1:0] sin_tc_c, cos_tc_c;
  logic signed [W-1:0] xs_c, ys_c, atan_c, z_r_c, z_w_c;
  logic [PW-1:0]       prod_c, mag_rnd_c;

  qsm_to_tc u_sin (.i_sm(i_sin), .o_tc_c(sin_tc_c));
  qsm_to_tc u_cos (.i_sm(i_cos), .o_tc_c(cos_tc_c));

  // Micro-rotation operands
  assign xs_c   = x_q >>> it_q;
  assign ys_c   = y_q >>> it_q;
  assign atan_c = atan_lut(it_q);

  // Gain compensation; x is non-negative after vectoring
  assign prod_c    = PW'($unsigned(x_q)) * PW'(K_INV);
  assign mag_rnd_c = (prod_c + RND) >> SH;

  // Round angle to Q12, then fold residual CORDIC error back into (-pi, pi]
  assign z_r_c = (z_q + W'(1 << (GUARD - 1))) >>> GUARD;
  assign z_w_c = (z_r_c > PI_W)   ? z_r_c - TWO_PI_W :
                 (z_r_c <= -PI_W) ? z_r_c + TWO_PI_W : z_r_c;

  // Next-state and datapath
  always_comb begin
    state_d  = state_q;
    it_d     = it_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    x_neg_d  = x_neg_q;
    y_neg_d  = y_neg_q;
    x_zero_d = x_zero_q;
    y_zero_d = y_zero_q;
    zero_d   = zero_q;
    axis_d   = axis_q;
    ang_d    = ang_q;
    mag_d    = mag_q;
    ovf_d    = ovf_q;
    angle_d  = angle_q;
    omag_d   = omag_q;
    valid_d  = 1'b0;
    busy_d   = busy_q;
    ozero_d  = ozero_q;
    oovf_d   = oovf_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_ROT;
          busy_d   = 1'b1;
          it_d     = 4'd0;
          x_neg_d  = cos_tc_c[W-1];
          y_neg_d  = sin_tc_c[W-1];
          x_zero_d = (cos_tc_c == '0);
          y_zero_d = (sin_tc_c == '0);
          zero_d   = (cos_tc_c == '0) && (sin_tc_c == '0);
          // On-axis inputs report the untouched axis magnitude
          axis_d   = (sin_tc_c == '0) ? i_cos[N-2:0] : i_sin[N-2:0];
          // Left half-plane: rotate by pi so CORDIC converges
          if (cos_tc_c[W-1]) begin
            x_d = -cos_tc_c;
            y_d = -sin_tc_c;
            z_d = sin_tc_c[W-1] ? -PI_G : PI_G;
          end else begin
            x_d = cos_tc_c;
            y_d = sin_tc_c;
            z_d = '0;
          end
        end
      end

      S_ROT: begin
        if (y_q[W-1]) begin
          x_d = x_q - ys_c;
          y_d = y_q + xs_c;
          z_d = z_q - atan_c;
        end else begin
          x_d = x_q + ys_c;
          y_d = y_q - xs_c;
          z_d = z_q + atan_c;
        end
        it_d = it_q + 4'd1;
        if (it_q == 4'(ITER - 1)) state_d = S_SCALE;
      end

      S_SCALE: begin
        state_d = S_DONE;
        ovf_d   = 1'b0;
        if (y_zero_q) begin
          // Covers the zero vector too; x<0 gives +pi exactly
          ang_d = x_neg_q ? N'(PI) : '0;
          mag_d = axis_q;
        end else if (x_zero_q) begin
          ang_d = y_neg_q ? -N'(HALF_PI) : N'(HALF_PI);
          mag_d = axis_q;
        end else begin
          ang_d = N'(z_w_c);
          if (mag_rnd_c > MAG_MAX) begin
            mag_d = '1;
            ovf_d = 1'b1;
          end else begin
            mag_d = mag_rnd_c[N-2:0];
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
`ifdef SINCOS_UNSIGNED_ANGLE_EN
        angle_d = {1'b0, NM1'(ang_q[N-1] ? ang_q + N'(TWO_PI) : ang_q)};
`else
        angle_d = {ang_q[N-1], NM1'(ang_q[N-1] ? -ang_q : ang_q)};
`endif
        omag_d  = {1'b0, mag_q};
        ozero_d = zero_q;
        oovf_d  = ovf_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      it_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      x_neg_q  <= 1'b0;
      y_neg_q  <= 1'b0;
      x_zero_q <= 1'b0;
      y_zero_q <= 1'b0;
      zero_q   <= 1'b0;
      axis_q   <= '0;
      ang_q    <= '0;
      mag_q    <= '0;
      ovf_q    <= 1'b0;
      angle_q  <= '0;
      omag_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ozero_q  <= 1'b0;
      oovf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      it_q     <= it_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      x_neg_q  <= x_neg_d;
      y_neg_q  <= y_neg_d;
      x_zero_q <= x_zero_d;
      y_zero_q <= y_zero_d;
      zero_q   <= zero_d;
      axis_q   <= axis_d;
      ang_q    <= ang_d;
      mag_q    <= mag_d;
      ovf_q    <= ovf_d;
      angle_q  <= angle_d;
      omag_q   <= omag_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ozero_q  <= ozero_d;
      oovf_q   <= oovf_d;
    end
  end

  assign o_angle    = angle_q;
  assign o_mag      = omag_q;
  assign o_valid    = valid_q;
  assign o_busy     = busy_q;
  assign o_zero     = ozero_q;
  assign o_overflow = oovf_q;

endmodule

// File: tb/tb_sincos_to_angle.sv
// Directed-vector bench for sincos_to_angle: table of hand-computed results
// plus sequences for ignored starts, back-to-back ops and mid-op reset.
module tb_sincos_to_angle;

  localparam int ITER = 14;
  localparam int TWO_PI_I = 25736;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [23:0] i_sin, i_cos;
  logic [23:0] o_angle, o_mag;
  logic        o_valid, o_busy, o_zero, o_overflow;

  int total = 0;
  int bad   = 0;

  sincos_to_angle #(.ITER(ITER)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .i_start   (i_start),
    .i_sin     (i_sin),
    .i_cos     (i_cos),
    .o_angle   (o_angle),
    .o_mag     (o_mag),
    .o_valid   (o_valid),
    .o_busy    (o_busy),
    .o_zero    (o_zero),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] s_in;
    logic [23:0] c_in;
    logic [23:0] ang;
    int          ang_tol;
    logic [23:0] mag;
    int          mag_tol;
    logic        zero;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  function automatic int sm2i(input logic [23:0] v);
    return v[23] ? -int'(v[22:0]) : int'(v[22:0]);
  endfunction

  // Expected angle as an integer in the range this build reports
  function automatic int exp_ang(input logic [23:0] v);
    int a;
    a = sm2i(v);
`ifdef SINCOS_UNSIGNED_ANGLE_EN
    if (a < 0) a = a + TWO_PI_I;
`endif
    return a;
  endfunction

  task automatic check(input string name, input int act, input int exp, input int tol);
    int diff;
    total++;
    diff = act - exp;
    if (diff < 0) diff = -diff;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) tol %0d",
               name, act, act, exp, exp, tol);
    end
  endtask

  // Start one op and wait for o_valid; lat = edges from acceptance to pulse
  task automatic run_op(input logic [23:0] s, input logic [23:0] c, output int lat);
    @(negedge clk);
    i_sin   = s;
    i_cos   = c;
    i_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_start = 1'b0;
    check("busy_after_start", int'(o_busy), 1, 0);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (o_valid) break;
    end
    if (!o_valid) check("valid_timeout", 0, 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int nv;
    int first_k;
    int second_k;
    logic [23:0] held;

    vecs[0] = '{24'h000000, 24'h001000, 24'h000000, 1, 24'h001000, 2, 1'b0, 1'b0};
    vecs[1] = '{24'h001000, 24'h000000, 24'h001922, 2, 24'h001000, 3, 1'b0, 1'b0};
    vecs[2] = '{24'h001000, 24'h001000, 24'h000C91, 2, 24'h0016A1, 3, 1'b0, 1'b0};
    vecs[3] = '{24'h801000, 24'h801000, 24'h8025B3, 2, 24'h0016A1, 3, 1'b0, 1'b0};
    vecs[4] = '{24'h000000, 24'h802000, 24'h003244, 0, 24'h002000, 0, 1'b0, 1'b0};
    vecs[5] = '{24'h800000, 24'h800000, 24'h000000, 0, 24'h000000, 0, 1'b1, 1'b0};
    vecs[6] = '{24'h7FFFFF, 24'h7FFFFF, 24'h000C91, 2, 24'h7FFFFF, 0, 1'b0, 1'b1};
    vecs[7] = '{24'h803000, 24'h004000, 24'h800A4C, 2, 24'h005000, 3, 1'b0, 1'b0};
    vecs[8] = '{24'h004000, 24'h803000, 24'h00236E, 2, 24'h005000, 3, 1'b0, 1'b0};
    vecs[9] = '{24'h801000, 24'h000000, 24'h801922, 2, 24'h001000, 3, 1'b0, 1'b0};

    rst_n   = 1'b0;
    i_start = 1'b0;
    i_sin   = '0;
    i_cos   = '0;
    repeat (3) @(negedge clk);
    check("reset_angle", int'(o_angle), 0, 0);
    check("reset_mag", int'(o_mag), 0, 0);
    check("reset_flags", int'({o_valid, o_busy, o_zero, o_overflow}), 0, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      run_op(vecs[v].s_in, vecs[v].c_in, lat);
      check($sformatf("v%0d_latency", v), lat, ITER + 2, 0);
      check($sformatf("v%0d_angle", v), sm2i(o_angle), exp_ang(vecs[v].ang), vecs[v].ang_tol);
      if (vecs[v].ang == 24'h000000)
        check($sformatf("v%0d_angle_sign", v), int'(o_angle[23]), 0, 0);
      check($sformatf("v%0d_mag", v), int'(o_mag), int'(vecs[v].mag), vecs[v].mag_tol);
      check($sformatf("v%0d_zero", v), int'(o_zero), int'(vecs[v].zero), 0);
      check($sformatf("v%0d_ovf", v), int'(o_overflow), int'(vecs[v].ovf), 0);
      check($sformatf("v%0d_busy_at_valid", v), int'(o_busy), 0, 0);
      held = o_angle;
      @(negedge clk);
      check($sformatf("v%0d_valid_pulse", v), int'(o_valid), 0, 0);
      check($sformatf("v%0d_angle_hold", v), int'(o_angle), int'(held), 0);
    end

    // Start pulse during ROT must be ignored
    @(negedge clk);
    i_sin = 24'h001000;
    i_cos = 24'h001000;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (3) @(negedge clk);
    i_sin = 24'h002000;
    i_cos = 24'h000000;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    nv = 0;
    held = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (o_valid) begin
        nv++;
        held = o_angle;
      end
    end
    check("ignored_start_count", nv, 1, 0);
    check("ignored_start_angle", sm2i(held), 3217, 2);

    // i_start held high: next op starts on the first IDLE cycle
    @(negedge clk);
    i_sin = 24'h004000;
    i_cos = 24'h803000;
    i_start = 1'b1;
    first_k = -1;
    second_k = -1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_valid) begin
        if (first_k < 0) first_k = k;
        else if (second_k < 0) begin
          second_k = k;
          i_start = 1'b0;
          check("b2b_angle", sm2i(o_angle), 9070, 2);
        end
      end
    end
    i_start = 1'b0;
    check("b2b_period", second_k - first_k, ITER + 3, 0);

    // Reset mid-ROT: outputs clear at once and no valid follows
    @(negedge clk);
    i_sin = 24'h001000;
    i_cos = 24'h001000;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_reset_busy", int'(o_busy), 1, 0);
    rst_n = 1'b0;
    #1;
    check("mid_reset_angle", int'(o_angle), 0, 0);
    check("mid_reset_mag", int'(o_mag), 0, 0);
    check("mid_reset_busy", int'(o_busy), 0, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (o_valid) nv++;
    end
    check("no_valid_after_reset", nv, 0, 0);

    // Restart after reset
    run_op(24'h803000, 24'h004000, lat);
    check("restart_latency", lat, ITER + 2, 0);
    check("restart_angle", sm2i(o_angle), exp_ang(24'h800A4C), 2);
    check("restart_mag", int'(o_mag), 24'h005000, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
